arbitro_vc_dest: RTL
====================

Name: arbitro_vc_dest

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the flow-control datapath.
- Enabled only while the control FSM reports ACTIVE.
- Each cycle it picks at most one eligible VC head word, pops it, and pushes it one cycle later into D0 or D1, selected by a destination bit in the word.
- Honours D-FIFO almost-full backpressure and reports idle and per-VC forwarded counts.

Parameters:
- BW, 6: data word width.
- DEST_BIT, 4: bit index of the word selecting the destination (0 = D0, 1 = D1).
- CNT_W, 8: width of the forwarded-word counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- active_in  in  1  control FSM is in ACTIVE; arbitration allowed only when 1.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  BW  VC0 head word; first-word-fall-through, valid while !vc0_empty.
- vc1_data  in  BW  VC1 head word; valid while !vc1_empty.
- d0_almost_full  in  1  D0 cannot accept a further pop.
- d1_almost_full  in  1  D1 cannot accept a further pop.
- vc0_pop  out  1  combinational pop strobe to VC0.
- vc1_pop  out  1  combinational pop strobe to VC1.
- d0_push  out  1  registered push strobe to D0.
- d1_push  out  1  registered push strobe to D1.
- data_out  out  BW  registered word for D0/D1, valid with d0_push or d1_push.
- idle_out  out  1  registered; both VCs empty and no push pending.
- cnt_vc0  out  CNT_W  words forwarded from VC0, saturating.
- cnt_vc1  out  CNT_W  words forwarded from VC1, saturating.

Behaviour:
- Reset values (reset=1 at an edge):
  - d0_push = d1_push = 0; data_out = 0; cnt_vc0 = cnt_vc1 = 0; idle_out = 1.
  - State = DISABLED; rr_last = 1 (next priority VC0).
  - vc*_pop = 0 while reset is high.
- States:
  - DISABLED: no pops. Goes to ARB at the first edge with active_in=1.
  - ARB: arbitration every cycle. Goes to DISABLED at the edge where active_in=0.
  - A pop already issued in the cycle active_in falls is still pushed at the next edge; no word is lost.
- Eligibility, in ARB only:
  - VCx is eligible when !vcx_empty and the D-FIFO chosen by vcx_data[DEST_BIT] has almost_full = 0.
- Grant:
  - At most one vc*_pop per cycle.
  - The priority rule is described under Optional Feature.
  - vcx_pop = grant_x, combinational from current inputs and state.
- Push (latency 1):
  - At the edge ending a grant cycle: data_out <= granted head word; d0_push or d1_push <= 1 per DEST_BIT.
  - Otherwise both push strobes <= 0 and data_out holds its value.
- Back-to-back grants to the same VC are legal.
  - The FIFO advances its head on the pop edge, so the next cycle sees a new head.
- The D-FIFO almost_full threshold must leave at least 1 free slot, to cover the in-flight push. This is the FIFO configuration's responsibility.
- Counters: cnt_vcx increments at each push sourced from VCx and saturates at 2^CNT_W-1 (no wrap).
- idle_out <= vc0_empty & vc1_empty & !(grant this cycle).
- Both D-FIFOs almost full: no grants, no pops. Stalls indefinitely without dropping words.
- Reset mid-operation: a pending push is discarded (push strobes forced to 0); the VC word already popped is lost. This is accepted.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both VCs are eligible, grant the one not granted last (rr_last register).
  - rr_last updates only on a grant.
  - A single eligible VC is always granted.
- Undefined:
  - Strict priority: VC0 is granted whenever eligible; VC1 only when VC0 is not eligible.
  - The rr_last register is not built.

Test Plan:
1. Reset held 2 cycles, active_in=1, both VCs loaded -> no pops; d*_push=0, idle_out=1, counters 0 during reset.
2. active_in=1, VC0 holds 0x05 (dest 0), VC1 empty, D FIFOs not full -> vc0_pop=1 in cycle N; cycle N+1 d0_push=1, data_out=0x05; cnt_vc0=1.
3. Both VCs non-empty with 3 words each, alternating dest:
   - Strict: all 3 VC0 words pushed first, then 3 VC1 words.
   - With ARB_ROUND_ROBIN_EN: VC0, VC1, VC0, VC1, VC0, VC1.
   - Final counts 3/3.
4. VC0 head 0x12 (dest 1), d1_almost_full=1, VC1 head 0x03 (dest 0) -> VC1 granted despite priority, d0_push with 0x03. Release d1_almost_full -> 0x12 pushed to D1 the next grant cycle.
5. active_in drops in the same cycle as a grant -> push still occurs at the next edge; no further pops while active_in=0; pops resume one cycle after active_in returns.
6. Force 260 VC0 transfers with CNT_W=8 -> cnt_vc0 holds at 255; idle_out=1 once both VCs empty and the last push has completed.

Source files
------------

// File: rtl/arbitro_vc_dest.sv
// VC0/VC1 -> D0/D1 scheduler: pops one eligible VC head per cycle and pushes it to the addressed D-FIFO a cycle later.
// Optional ARB_ROUND_ROBIN_EN selects round-robin between VCs; default build uses strict VC0 priority.
module arbitro_vc_dest #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_in,
  input  logic             vc0_empty,
  input  logic             vc1_empty,
  input  logic [BW-1:0]    vc0_data,
  input  logic [BW-1:0]    vc1_data,
  input  logic             d0_almost_full,
  input  logic             d1_almost_full,
  output logic             vc0_pop,
  output logic             vc1_pop,
  output logic             d0_push,
  output logic             d1_push,
  output logic [BW-1:0]    data_out,
  output logic             idle_out,
  output logic [CNT_W-1:0] cnt_vc0,
  output logic [CNT_W-1:0] cnt_vc1
);

  typedef enum logic {DISABLED = 1'b0, ARB = 1'b1} state_t;

  state_t state_reg, state_next;

  logic          elig0, elig1;
  logic          grant0, grant1, grant_any;
  logic [BW-1:0] sel_data;

  logic             d0_push_reg, d1_push_reg, idle_reg;
  logic [BW-1:0]    data_reg;
  logic [CNT_W-1:0] cnt0_reg, cnt1_reg;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef ARB_ROUND_ROBIN_EN
  // 1 means VC1 was granted last, so VC0 wins the next tie.
  logic rr_last_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= DISABLED;
    else       state_reg <= state_next;
  end

  // A grant made in the cycle active_in falls is still honoured, since the state only leaves ARB at that edge.
  always_comb begin
    state_next = state_reg;
    elig0      = 1'b0;
    elig1      = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_reg)
      DISABLED: if (active_in) state_next = ARB;
      ARB: begin
        if (!active_in) state_next = DISABLED;
        if (!reset) begin
          elig0 = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
          elig1 = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (elig0 && elig1) begin
          grant0 = rr_last_reg;
          grant1 = !rr_last_reg;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
`else
        grant0 = elig0;
        grant1 = elig1 && !elig0;
`endif
      end
      default: state_next = DISABLED;
    endcase
  end

  assign grant_any = grant0 | grant1;
  assign sel_data  = grant1 ? vc1_data : vc0_data;
  assign vc0_pop   = grant0;
  assign vc1_pop   = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_push_reg <= 1'b0;
      d1_push_reg <= 1'b0;
      data_reg    <= '0;
      idle_reg    <= 1'b1;
      cnt0_reg    <= '0;
      cnt1_reg    <= '0;
    end else begin
      d0_push_reg <= grant_any && !sel_data[DEST_BIT];
      d1_push_reg <= grant_any &&  sel_data[DEST_BIT];
      if (grant_any) data_reg <= sel_data;
      idle_reg <= vc0_empty && vc1_empty && !grant_any;
      if (grant0 && cnt0_reg != CNT_MAX) cnt0_reg <= cnt0_reg + 1'b1;
      if (grant1 && cnt1_reg != CNT_MAX) cnt1_reg <= cnt1_reg + 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)          rr_last_reg <= 1'b1;
    else if (grant_any) rr_last_reg <= grant1;
  end
`endif

  assign d0_push  = d0_push_reg;
  assign d1_push  = d1_push_reg;
  assign data_out = data_reg;
  assign idle_out = idle_reg;
  assign cnt_vc0  = cnt0_reg;
  assign cnt_vc1  = cnt1_reg;

endmodule
